// File: rtl/btn_debounce_bank.sv
// Five-channel button conditioner: 2-FF synchroniser, per-channel debounce FSM,
// registered level plus press/release/long-press strobes.
module btn_debounce_bank #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic [4:0] btn_hold
);

  localparam int unsigned NCH = 5;
  localparam int unsigned CW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  state_t        r_state  [NCH];
  logic [CW-1:0] r_cnt    [NCH];
  logic [HW-1:0] r_hcnt   [NCH];
  logic [4:0]    r_hfired;
  logic [4:0]    r_level;
  logic [4:0]    r_press;
  logic [4:0]    r_release;
  logic [4:0]    r_hold;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // hcnt advances on every edge that sees s2=1 while accepted-pressed, including
  // the edge that leaves RELEASE_WAIT, so a bounce delays the hold by exactly the
  // cycles spent in RELEASE_WAIT. r_hfired makes the hold strobe one-shot.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
        r_hcnt[i]  <= '0;
      end
      r_hfired  <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_hold    <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      r_hold    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        case (r_state[i])
          IDLE: begin
            if (r_s2[i]) begin
              r_state[i] <= PRESS_WAIT;
              r_cnt[i]   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!r_s2[i]) begin
              r_state[i] <= IDLE;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_state[i]  <= PRESSED;
              r_level[i]  <= 1'b1;
              r_press[i]  <= 1'b1;
              r_hcnt[i]   <= '0;
              r_hfired[i] <= 1'b0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
          PRESSED: begin
            if (r_s2[i]) begin
              if (r_hcnt[i] == HCNT_LAST) begin
                if (!r_hfired[i]) begin
                  r_hold[i]   <= 1'b1;
                  r_hfired[i] <= 1'b1;
                end
              end else begin
                r_hcnt[i] <= r_hcnt[i] + 1'b1;
              end
            end else begin
              r_state[i] <= RELEASE_WAIT;
              r_cnt[i]   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (r_s2[i]) begin
              r_state[i] <= PRESSED;
              if (r_hcnt[i] == HCNT_LAST) begin
                if (!r_hfired[i]) begin
                  r_hold[i]   <= 1'b1;
                  r_hfired[i] <= 1'b1;
                end
              end else begin
                r_hcnt[i] <= r_hcnt[i] + 1'b1;
              end
            end else if (r_cnt[i] == CNT_LAST) begin
              r_state[i]   <= IDLE;
              r_level[i]   <= 1'b0;
              r_release[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_hold    = r_hold;

endmodule
